// File: rtl/action_table.sv
// Action table: maps a match result (hit + index) to an action word, with a
// programmable default for misses, a saturating miss counter and an AXI4-Lite control port.
module action_table #(
  parameter int                  NUM_ENTRIES = 64,
  parameter int                  ACTION_W    = 32,
  parameter int                  TAG_W       = 16,
  parameter logic [ACTION_W-1:0] DEFAULT_RST = '0,
  parameter int                  IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [17:0]         s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [17:0]         s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic                lk_hit,
  input  logic [IDX_W-1:0]    lk_index,
  input  logic [TAG_W-1:0]    lk_tag,
  output logic                act_valid,
  input  logic                act_ready,
  output logic [ACTION_W-1:0] act_action,
  output logic [TAG_W-1:0]    act_tag,
  output logic                act_default
);

  localparam logic [17:0] ADDR_CNT = 18'h3FFF8;
  localparam logic [17:0] ADDR_DEF = 18'h3FFFC;
  localparam int          STAGES   = 2;

  typedef struct packed {
    logic [ACTION_W-1:0] action;
    logic [TAG_W-1:0]    tag;
    logic                dflt;
  } res_t;

  function automatic logic is_entry(input logic [17:0] a);
    return (a[1:0] == 2'b00) && (32'(a[17:2]) < NUM_ENTRIES);
  endfunction

  logic                live;
  logic [ACTION_W-1:0] tbl [NUM_ENTRIES];
  logic [ACTION_W-1:0] dflt_act;
  logic [31:0]         miss_cnt;
  logic [STAGES:1]     vld_pipe;
  res_t                s1, s2;

  logic                wr_acc, rd_acc, adv, lk_miss;
  logic                wr_ent, wr_cnt, wr_def;
  logic [IDX_W-1:0]    wr_idx;
  logic [31:0]         wr_old, wr_new, rd_data;
  logic                rd_err;
  logic [ACTION_W-1:0] lk_action;

  // live holds the handshake readies low until the first edge after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) live <= 1'b0;
    else     live <= 1'b1;

  assign wr_acc        = live & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
  assign s_axi_awready = wr_acc;
  assign s_axi_wready  = wr_acc;
  assign s_axi_arready = live & ~s_axi_rvalid;
  assign rd_acc        = s_axi_arvalid & s_axi_arready;

  assign wr_ent = is_entry(s_axi_awaddr);
  assign wr_cnt = (s_axi_awaddr == ADDR_CNT);
  assign wr_def = (s_axi_awaddr == ADDR_DEF);
  assign wr_idx = s_axi_awaddr[IDX_W+1:2];

  always_comb begin
    wr_old = wr_ent ? 32'(tbl[wr_idx]) : 32'(dflt_act);
    wr_new = wr_old;
    for (int b = 0; b < 4; b++)
      if (s_axi_wstrb[b]) wr_new[8*b +: 8] = s_axi_wdata[8*b +: 8];
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (is_entry(s_axi_araddr))        rd_data = 32'(tbl[s_axi_araddr[IDX_W+1:2]]);
    else if (s_axi_araddr == ADDR_CNT) rd_data = miss_cnt;
    else if (s_axi_araddr == ADDR_DEF) rd_data = 32'(dflt_act);
    else                               rd_err  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl[i] <= '0;
      dflt_act <= DEFAULT_RST;
    end else if (wr_acc) begin
      if (wr_ent)      tbl[wr_idx] <= ACTION_W'(wr_new);
      else if (wr_def) dflt_act    <= ACTION_W'(wr_new);
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else if (wr_acc) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= (wr_ent | wr_cnt | wr_def) ? 2'b00 : 2'b10;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else if (rd_acc) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_data;
      s_axi_rresp  <= rd_err ? 2'b10 : 2'b00;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end

  // Table is read at S1 capture, so a same-edge AXI write is not yet visible
  assign adv       = ~vld_pipe[2] | act_ready;
  assign lk_ready  = adv;
  assign lk_miss   = ~lk_hit | (32'(lk_index) >= NUM_ENTRIES);
  assign lk_action = lk_miss ? dflt_act : tbl[lk_index];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[1], lk_valid};
      s1       <= '{action: lk_action, tag: lk_tag, dflt: lk_miss};
      s2       <= s1;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst)                                         miss_cnt <= '0;
    else if (wr_acc && wr_cnt)                       miss_cnt <= '0;
    else if (adv && vld_pipe[1] && s1.dflt && ~&miss_cnt) miss_cnt <= miss_cnt + 32'd1;

  assign act_valid   = vld_pipe[2];
  assign act_action  = s2.action;
  assign act_tag     = s2.tag;
  assign act_default = s2.dflt;

endmodule

// File: tb/tb_action_table.sv
// Randomised bench for action_table: a table/queue model predicts every AXI
// response and lookup result; directed steps pin literal values.
module tb_action_table;
  localparam int          NE   = 64;
  localparam int          AW   = 32;
  localparam int          TW   = 16;
  localparam int          IW   = 6;
  localparam logic [31:0] DRST = 32'h0;
  localparam logic [17:0] A_CNT = 18'h3FFF8;
  localparam logic [17:0] A_DEF = 18'h3FFFC;

  logic clk = 1'b0, rst = 1'b1;
  logic [17:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic lk_valid = 0, lk_hit = 0, act_ready = 1;
  logic [IW-1:0] lk_index = '0;
  logic [TW-1:0] lk_tag = '0;
  logic lk_ready, act_valid, act_default;
  logic [AW-1:0] act_action;
  logic [TW-1:0] act_tag;

  action_table #(.NUM_ENTRIES(NE), .ACTION_W(AW), .TAG_W(TW), .DEFAULT_RST(DRST)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_hit(lk_hit), .lk_index(lk_index),
    .lk_tag(lk_tag), .act_valid(act_valid), .act_ready(act_ready),
    .act_action(act_action), .act_tag(act_tag), .act_default(act_default));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] action; logic [15:0] tag; logic dflt; } res_t;
  logic [31:0] m_tbl [NE];
  logic [31:0] m_def, m_cnt;
  res_t        exp_q[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic [1:0]  bq[$];

  function automatic logic [31:0] amask();
    return 32'((64'd1 << AW) - 64'd1);
  endfunction

  function automatic logic m_is_entry(input logic [17:0] a);
    return (a % 4 == 0) && (a / 4 < NE);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) m_tbl[i] = '0;
    m_def = DRST; m_cnt = 0;
    exp_q.delete(); rq_data.delete(); rq_resp.delete(); bq.delete();
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r & amask();
  endfunction

  initial m_reset();

  // Single compare/update process: inputs and handshake state are stable at
  // negedge; reads/lookups see state before a write accepted on the same edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_act_valid", 32'(act_valid), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_arready", 32'(arready), 0);
      chk("rst_awready", 32'(awready), 0);
      m_reset();
    end else begin
      chk("lk_ready", 32'(lk_ready), 32'(!act_valid || act_ready));
      if (act_valid) begin
        if (exp_q.size() == 0) chk("act_spurious", 32'(act_valid), 0);
        else begin
          chk("act_action", 32'(act_action), exp_q[0].action);
          chk("act_tag", 32'(act_tag), 32'(exp_q[0].tag));
          chk("act_default", 32'(act_default), 32'(exp_q[0].dflt));
          if (act_ready) void'(exp_q.pop_front());
        end
      end
      if (lk_valid && lk_ready) begin
        res_t r;
        r.tag  = lk_tag;
        r.dflt = !lk_hit || (int'(lk_index) >= NE);
        r.action = r.dflt ? m_def : m_tbl[lk_index];
        if (r.dflt && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        exp_q.push_back(r);
      end
      if (rvalid && rready) begin
        if (rq_data.size() == 0) chk("r_spurious", 32'(rvalid), 0);
        else begin
          chk("rdata", rdata, rq_data.pop_front());
          chk("rresp", 32'(rresp), 32'(rq_resp.pop_front()));
        end
      end
      if (arvalid && arready) begin
        if (m_is_entry(araddr))   begin rq_data.push_back(m_tbl[araddr / 4]); rq_resp.push_back(2'b00); end
        else if (araddr == A_CNT) begin rq_data.push_back(m_cnt); rq_resp.push_back(2'b00); end
        else if (araddr == A_DEF) begin rq_data.push_back(m_def); rq_resp.push_back(2'b00); end
        else                      begin rq_data.push_back(0);     rq_resp.push_back(2'b10); end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_spurious", 32'(bvalid), 0);
        else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
      end
      if (awvalid && wvalid && awready) begin
        if (m_is_entry(awaddr))   begin m_tbl[awaddr / 4] = merge(m_tbl[awaddr / 4], wdata, wstrb); bq.push_back(2'b00); end
        else if (awaddr == A_CNT) begin m_cnt = 0; bq.push_back(2'b00); end
        else if (awaddr == A_DEF) begin m_def = merge(m_def, wdata, wstrb); bq.push_back(2'b00); end
        else                      bq.push_back(2'b10);
      end
    end
  end

  // ---------------- drivers (all start and end at posedge+1) ----------------
  task automatic axi_wr(input logic [17:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0; do begin @(negedge clk); n++; end while (!awready && n < 50);
    chk("aw_accept", 32'(awready), 1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0; bready = 1;
    n = 0; do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    chk("bvalid_seen", 32'(bvalid), 1);
    resp = bresp;
    @(posedge clk); #1 bready = 0;
  endtask

  task automatic axi_rd(input logic [17:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1;
    n = 0; do begin @(negedge clk); n++; end while (!arready && n < 50);
    chk("ar_accept", 32'(arready), 1);
    @(posedge clk); #1 arvalid = 0; rready = 1;
    n = 0; do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    chk("rvalid_seen", 32'(rvalid), 1);
    d = rdata; resp = rresp;
    @(posedge clk); #1 rready = 0;
  endtask

  task automatic lk_send(input logic hit, input logic [IW-1:0] idx, input logic [TW-1:0] tag);
    int n;
    lk_valid = 1; lk_hit = hit; lk_index = idx; lk_tag = tag;
    n = 0; do begin @(negedge clk); n++; end while (!lk_ready && n < 50);
    chk("lk_accept", 32'(lk_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_act(output logic [31:0] a, output logic [15:0] tag, output logic d, output int at);
    int n;
    n = 0; do begin @(negedge clk); n++; end while (!(act_valid && act_ready) && n < 50);
    chk("act_seen", 32'(act_valid && act_ready), 1);
    a = act_action; tag = act_tag; d = act_default; at = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic [31:0] d;
  logic [1:0]  rs;
  logic [31:0] a;
  logic [15:0] tg;
  logic        df;
  int          at, prev;
  bit          lk_done, axi_done;

  initial begin
    // reset and release
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); chk("arready_pre", 32'(arready), 0);
    @(negedge clk); chk("arready_post", 32'(arready), 1);
    @(posedge clk); #1;
    axi_rd(A_DEF, d, rs);  chk("rst_def", d, DRST);
    axi_rd(18'h4, d, rs);  chk("rst_e1", d, 0);
    axi_rd(A_CNT, d, rs);  chk("rst_cnt", d, 0);

    // program and hit, two-cycle latency
    axi_wr(A_DEF, 32'h2, 4'hF, rs);  chk("def_wr_ok", 32'(rs), 0);
    axi_wr(18'hC, 32'hA5, 4'hF, rs);
    lk_send(1, 3, 16'h11); lk_valid = 0;
    @(negedge clk); chk("hit_lat1", 32'(act_valid), 0);
    @(negedge clk); chk("hit_lat2", 32'(act_valid), 1);
    chk("hit_action", 32'(act_action), 32'hA5);
    chk("hit_tag", 32'(act_tag), 32'h11);
    chk("hit_dflt", 32'(act_default), 0);
    @(posedge clk); #1;

    // five misses back to back
    fork
      begin for (int i = 0; i < 5; i++) lk_send(0, IW'(i), TW'(16'h50 + i)); lk_valid = 0; end
      begin
        for (int i = 0; i < 5; i++) begin
          wait_act(a, tg, df, at);
          chk("miss_action", a, 32'h2);
          chk("miss_dflt", 32'(df), 1);
          if (i > 0) chk("miss_consec", 32'(at), 32'(prev + 1));
          prev = at;
        end
      end
    join
    @(posedge clk); #1;
    axi_rd(A_CNT, d, rs);  chk("cnt5", d, 5);
    axi_wr(A_CNT, 32'h0, 4'h0, rs);
    axi_rd(A_CNT, d, rs);  chk("cnt_clr", d, 0);

    // byte strobes and bad addresses
    axi_wr(18'h0, 32'h1234_5678, 4'b0010, rs);
    axi_rd(18'h0, d, rs);  chk("strb_e0", d, 32'h0000_5600);
    axi_wr(18'h20000, 32'hFFFF_FFFF, 4'hF, rs);  chk("bad_bresp", 32'(rs), 32'h2);
    axi_rd(18'hC, d, rs);  chk("bad_wr_noeffect", d, 32'hA5);
    axi_rd(18'h20000, d, rs);
    chk("bad_rresp", 32'(rs), 32'h2);
    chk("bad_rdata", d, 0);

    // back-pressure: stall four cycles under a continuous stream
    fork
      begin for (int i = 0; i < 10; i++) lk_send(1, IW'(i), TW'(16'h100 + i)); lk_valid = 0; end
      begin
        repeat (3) @(posedge clk); #1 act_ready = 0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk); chk("stall_lk_ready", 32'(lk_ready), 0);
          @(posedge clk); #1;
        end
        act_ready = 1;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          wait_act(a, tg, df, at);
          chk("bp_order", 32'(tg), 32'(16'h100 + i));
        end
      end
    join
    @(posedge clk); #1;

    // write/lookup race on entry 1
    fork
      axi_wr(18'h4, 32'h7, 4'hF, rs);
      begin lk_send(1, 1, 16'h21); lk_send(1, 1, 16'h22); lk_valid = 0; end
      begin
        wait_act(a, tg, df, at); chk("race_old", a, 0);
        wait_act(a, tg, df, at); chk("race_new", a, 32'h7);
      end
    join
    @(posedge clk); #1;

    // reset mid-stream
    for (int i = 0; i < 3; i++) lk_send(0, 0, TW'(16'h300 + i));
    #1 rst = 1;
    #1 chk("midrst_act_valid", 32'(act_valid), 0);
    lk_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    axi_rd(A_DEF, d, rs);  chk("midrst_def", d, DRST);
    axi_rd(18'hC, d, rs);  chk("midrst_e3", d, 0);

    // randomised traffic on both ports
    lk_done = 0; axi_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin lk_valid = 0; @(posedge clk); #1; end
          lk_send($urandom_range(3) != 0, IW'($urandom), TW'($urandom));
        end
        lk_valid = 0; lk_done = 1;
      end
      begin
        while (!(lk_done && axi_done)) begin
          act_ready = ($urandom_range(3) != 0);
          @(posedge clk); #1;
        end
        act_ready = 1;
      end
      begin
        for (int k = 0; k < 60; k++) begin
          case ($urandom_range(5))
            0, 1, 2: axi_wr(18'(4 * $urandom_range(NE - 1)), $urandom, 4'($urandom), rs);
            3:       axi_wr(A_DEF, $urandom, 4'($urandom), rs);
            4:       axi_rd($urandom_range(1) ? A_DEF : 18'(4 * $urandom_range(NE - 1)), d, rs);
            default: if ($urandom_range(1)) axi_rd(18'h10000 + 18'($urandom_range(4095)), d, rs);
                     else axi_wr(18'h10000 + 18'($urandom_range(4095)), $urandom, 4'hF, rs);
          endcase
        end
        axi_done = 1;
      end
    join
    repeat (6) @(posedge clk); #1;
    axi_rd(A_CNT, d, rs);
    chk("cnt_vs_model", d, m_cnt);
    repeat (2) @(posedge clk); #1;
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("rq_empty", 32'(rq_data.size()), 0);
    chk("bq_empty", 32'(bq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
